pio_irq_arbiter: RTL and testbench
==================================

# pio_irq_arbiter

Round-robin service controller for up to N_SRC edge-capturing PIO interrupt slaves (light sensor, G-sensor, key PIOs) in the sensor Qsys subsystem. On a pending source `irq` it reads the PIO data register, clears that PIO's edge-capture register, and queues a timestamped event word in a small FIFO. Software drains the FIFO through a valid/ready stream and sees one aggregated interrupt. The PIO cores are serviced and re-armed without CPU register traffic.

## Interface
- `N_SRC`, 4: number of PIO sources, 1..8.
- `FIFO_DEPTH`, 8: event FIFO entries, power of two, 2..64.
- `TS_W`, 16: timestamp field width.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `src_irq` in N_SRC: per-PIO `irq` outputs.
- `pio_chipselect` out N_SRC: one-hot select of the serviced PIO.
- `pio_address` out 2: shared PIO register address.
- `pio_write_n` out 1: shared active-low write strobe.
- `pio_writedata` out 32: shared write data.
- `pio_readdata` in N_SRC*32: concatenated PIO `readdata`; source k occupies bits [32k+31:32k].
- `evt_data` out TS_W+4: event word {timestamp, level, 3-bit source index}.
- `evt_valid` out 1: FIFO non-empty.
- `evt_ready` in 1: consumer pops the head when high with `evt_valid`.
- `irq_out` out 1: aggregated interrupt, registered copy of `evt_valid`.
- `overflow_cnt` out 8: saturating count of stalled grant opportunities.

## Operation
- FSM states: IDLE, READ, CAPT, CLEAR.
- **IDLE**
  - Grants when any `src_irq` is high and the FIFO is not full.
  - Grant is round robin: the search starts at last_grant+1 modulo N_SRC, and the first high source wins.
  - On grant, stores the index in gnt and goes to READ.
- **READ**
  - Drives `pio_chipselect[gnt]`=1, `pio_address`=0, `pio_write_n`=1.
  - Goes to CAPT.
- **CAPT**
  - Keeps the same address.
  - Samples bit 0 of slice gnt of `pio_readdata` as level.
  - Goes to CLEAR.
- **CLEAR**
  - Drives `pio_chipselect[gnt]`=1, `pio_address`=3, `pio_write_n`=0, `pio_writedata`=0.
  - Pushes {ts, level, gnt} into the FIFO.
  - Sets last_grant=gnt and returns to IDLE.
- Idle outputs: `pio_chipselect`=0, `pio_address`=0, `pio_write_n`=1, `pio_writedata`=0.
- **Full FIFO:** no grant is issued. Edge captures stay latched in the PIOs, so no event is lost. `overflow_cnt` increments once per cycle spent in IDLE with an irq pending and the FIFO full. It saturates at 255.
- **Push and pop in the same cycle:** allowed at any occupancy, including when full. The pop is evaluated first.
- Source indices at or above N_SRC are never granted.
- **Reset (any time, including mid-sequence):**
  - FSM to IDLE, FIFO emptied, last_grant=N_SRC-1.
  - Counters 0, all outputs at idle values.
  - `evt_valid`=0, `irq_out`=0, `evt_data`=0.

## Timing
- Service sequence is 4 cycles from grant to push: IDLE, READ, CAPT, CLEAR.
- The event appears at `evt_valid` in the cycle after CLEAR; `irq_out` follows one cycle later.
- The PIO clears its `irq` one cycle after the CLEAR write. IDLE must not re-grant the same source on the stale `irq`, so the source serviced in the previous CLEAR is masked for that one IDLE cycle.
- Maximum throughput is one event per 4 cycles.
- `evt_data` is the FIFO head, combinationally valid while `evt_valid`=1.

## Configuration
- `PIO_IRQ_ARB_TIMESTAMP_EN` defined:
  - A free-running TS_W-bit cycle counter is compiled in, reset to 0 and wrapping at 2^TS_W.
  - Its value in the CLEAR cycle fills the timestamp field.
- Undefined:
  - No counter is built and the timestamp field is constant 0.
  - `evt_data` width is unchanged.

## Test plan
- **Single source:** PIO model 1 edge, `src_irq`=4'b0010, `evt_ready`=1.
  - PIO 1 sees a read at address 0, then a write at address 3 with writedata 0.
  - Event {ts, level 1, index 1}.
- **Round robin:** all four `src_irq` high from reset. Grants are 0,1,2,3 on consecutive 4-cycle services, then 0 again if re-asserted.
- **FIFO full:** FIFO_DEPTH=2, `evt_ready`=0, three sources pending.
  - Two events are queued, then no chipselect activity.
  - `overflow_cnt` increments each cycle and stops at 255.
  - Raising `evt_ready` resumes service of the third source.
- **Simultaneous pop and push at full:** occupancy stays at FIFO_DEPTH with no data corruption; head order is preserved.
- **Reset in CAPT:** `reset` pulse causes outputs idle within the same cycle, `evt_valid`=0, `irq_out`=0. After release, the still-pending source is re-serviced from IDLE.
- **Timestamp:** with `PIO_IRQ_ARB_TIMESTAMP_EN`, two events 100 cycles apart differ by 100 in the timestamp field. Without it the field reads 0.

Source files
------------

// File: rtl/pio_irq_arbiter.sv
// pio_irq_arbiter
//   Round-robin service controller for edge-capturing PIO interrupt slaves.
//   A pending source is read (address 0), its data bit 0 is captured as the
//   event level, and its edge-capture register is cleared (address 3, data 0).
//   Each service pushes {timestamp, level, source index} into an event FIFO.
//   Software drains the FIFO over a valid/ready stream and sees one
//   aggregated interrupt.
//
//   Optional feature macro: PIO_IRQ_ARB_TIMESTAMP_EN
//     defined   : free-running TS_W-bit cycle counter fills the timestamp field
//     undefined : timestamp field is constant 0 (event width unchanged)
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   src_irq           per-PIO irq lines
//   pio_chipselect    one-hot select of the serviced PIO
//   pio_address       shared register address
//   pio_write_n       shared active-low write strobe
//   pio_writedata     shared write data (always 0: clears edge capture)
//   pio_readdata      concatenated readdata, source k at [32k+31:32k]
//   evt_data          FIFO head {ts, level, idx[2:0]}, 0 when empty
//   evt_valid         FIFO non-empty
//   evt_ready         consumer pop strobe
//   irq_out           registered copy of evt_valid
//   overflow_cnt      saturating count of IDLE cycles stalled by a full FIFO
module pio_irq_arbiter #(
  parameter int N_SRC      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      src_irq,
  output logic [N_SRC-1:0]      pio_chipselect,
  output logic [1:0]            pio_address,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  input  logic [N_SRC*32-1:0]   pio_readdata,
  output logic [TS_W+3:0]       evt_data,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic                  irq_out,
  output logic [7:0]            overflow_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = TS_W + 4;

  typedef enum logic [1:0] {IDLE, READ, CAPT, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [2:0]       gnt, last_grant, pick;
  logic             mask_last, level, rd_bit;
  logic             grant, any_pend, full, push, pop, ovf_inc;
  logic [N_SRC-1:0] elig;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [TS_W-1:0]  ts_val;
  int               d, best_d;

  // only bit 0 of each readdata slice carries the level
  logic unused_rd;
  assign unused_rd = ^pio_readdata;

  // Eligible sources: the one cleared in the previous cycle still shows a
  // stale irq for one cycle, so it is masked in the first IDLE after CLEAR.
  // Winner is the eligible source with the smallest rotational distance
  // past last_grant.
  always_comb begin
    elig   = src_irq;
    pick   = last_grant;
    best_d = N_SRC;
    d      = 0;
    for (int k = 0; k < N_SRC; k++)
      if (mask_last && last_grant == 3'(k)) elig[k] = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (elig[k]) begin
        d = k - int'(last_grant) - 1;
        if (d < 0) d = d + N_SRC;
        if (d < best_d) begin
          best_d = d;
          pick   = 3'(k);
        end
      end
    end
    any_pend = |elig;
  end

  always_comb begin
    rd_bit = 1'b0;
    for (int k = 0; k < N_SRC; k++)
      if (gnt == 3'(k)) rd_bit = pio_readdata[32*k];
  end

  // next state
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    ovf_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          if (!full) begin
            grant   = 1'b1;
            state_d = READ;
          end else begin
            ovf_inc = 1'b1;
          end
        end
      end
      READ:    state_d = CAPT;
      CAPT:    state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PIO bus: read held through READ/CAPT, clear write in CLEAR
  always_comb begin
    pio_chipselect = '0;
    pio_address    = 2'd0;
    pio_write_n    = 1'b1;
    pio_writedata  = 32'd0;
    if (state_q != IDLE)
      for (int k = 0; k < N_SRC; k++) pio_chipselect[k] = (gnt == 3'(k));
    if (state_q == CLEAR) begin
      pio_address = 2'd3;
      pio_write_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt          <= '0;
      last_grant   <= 3'(N_SRC-1);
      mask_last    <= 1'b0;
      level        <= 1'b0;
      overflow_cnt <= '0;
      irq_out      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_last <= (state_q == CLEAR);
      irq_out   <= evt_valid;
      if (grant) gnt <= pick;
      if (state_q == CAPT) level <= rd_bit;
      if (state_q == CLEAR) last_grant <= gnt;
      if (ovf_inc && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

`ifdef PIO_IRQ_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end
  assign ts_val = ts_cnt;
`else
  assign ts_val = '0;
`endif

  // Event FIFO; pop is taken first so a push is accepted even when full.
  assign evt_valid = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign push      = (state_q == CLEAR) && (!full || pop);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ts_val, level, gnt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_irq_arbiter.sv
// Bench for pio_irq_arbiter: PIO edge-capture models, a cycle-level
// behavioural reference (phase counter + event queue) compared every
// cycle, directed literal checks, then randomized traffic.
module tb_pio_irq_arbiter;
  localparam int N  = 4;
  localparam int D  = 2;
  localparam int TW = 16;
  localparam int EW = TW + 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      src_irq;
  logic [N-1:0]      pio_chipselect;
  logic [1:0]        pio_address;
  logic              pio_write_n;
  logic [31:0]       pio_writedata;
  logic [N*32-1:0]   pio_readdata;
  logic [EW-1:0]     evt_data;
  logic              evt_valid;
  logic              evt_ready = 1'b0;
  logic              irq_out;
  logic [7:0]        overflow_cnt;

  pio_irq_arbiter #(.N_SRC(N), .FIFO_DEPTH(D), .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq),
    .pio_chipselect(pio_chipselect), .pio_address(pio_address),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .evt_data(evt_data), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .irq_out(irq_out), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // ---------------- PIO models: edge capture, clear lands one cycle late
  logic [N-1:0] cap = '0;
  logic [N-1:0] clr_pend = '0;
  logic [N-1:0] edge_in = '0;
  logic [31:0]  pdata [N];

  initial for (int k = 0; k < N; k++) pdata[k] = 32'd0;

  assign src_irq = cap;
  always_comb begin
    pio_readdata = '0;
    for (int k = 0; k < N; k++) pio_readdata[k*32 +: 32] = pdata[k];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      clr_pend[k] <= pio_chipselect[k] && !pio_write_n && pio_address == 2'd3;
      if (clr_pend[k]) cap[k] <= edge_in[k];
      else if (edge_in[k]) cap[k] <= 1'b1;
    end
  end

  // ---------------- reference model
  // ph: 0 idle, 1 read, 2 capture, 3 clear
  int            ph = 0, cur = 0, lastg = N-1, ovf = 0, ts = 0;
  bit            jc = 0, irq_e = 0, lvl = 0, m_push, m_found, m_irqn;
  logic [EW-1:0] q[$];
  logic [EW-1:0] m_w;
  logic [N-1:0]  m_el;
  logic [TW-1:0] m_ts;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; cur = 0; lastg = N-1; jc = 0; ovf = 0; irq_e = 0; ts = 0;
      q.delete();
    end else begin
      m_irqn = (q.size() > 0);
      m_push = 0;
`ifdef PIO_IRQ_ARB_TIMESTAMP_EN
      m_ts = TW'(ts);
`else
      m_ts = '0;
`endif
      case (ph)
        0: begin
          m_el = src_irq;
          if (jc) m_el[lastg] = 1'b0;
          jc = 0;
          if (m_el != 0) begin
            if (q.size() < D) begin
              m_found = 0;
              for (int i = 1; i <= N; i++) begin
                if (!m_found && m_el[(lastg + i) % N]) begin
                  cur = (lastg + i) % N;
                  m_found = 1;
                end
              end
              ph = 1;
            end else if (ovf < 255) begin
              ovf++;
            end
          end
        end
        1: ph = 2;
        2: begin lvl = pio_readdata[cur*32]; ph = 3; end
        default: begin
          m_w = {m_ts, lvl, 3'(cur)};
          m_push = 1; lastg = cur; ph = 0; jc = 1;
        end
      endcase
      if (q.size() > 0 && evt_ready) void'(q.pop_front());
      if (m_push) q.push_back(m_w);
      irq_e = m_irqn;
      ts = (ts + 1) % (2**TW);
    end
  end

  // ---------------- per-cycle compare
  logic [N-1:0] e_cs;
  always @(negedge clk) begin
    if (en) begin
      e_cs = (ph != 0) ? N'(1 << cur) : '0;
      chk("chipselect", pio_chipselect, e_cs);
      chk("address", pio_address, (ph == 3) ? 2'd3 : 2'd0);
      chk("write_n", pio_write_n, (ph == 3) ? 1'b0 : 1'b1);
      chk("writedata", pio_writedata, 32'd0);
      chk("evt_valid", evt_valid, q.size() > 0);
      if (q.size() > 0) chk("evt_data", evt_data, q[0]);
      chk("irq_out", irq_out, irq_e);
      chk("overflow_cnt", overflow_cnt, ovf);
    end
  end

  // ---------------- helpers
  task automatic raise(input logic [N-1:0] m);
    edge_in = m;
    @(negedge clk);
    edge_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic wait_clear(output logic [N-1:0] cs);
    int n = 0;
    cs = '0;
    while (!(pio_write_n == 1'b0 && pio_chipselect != '0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) expire("wait_clear");
    else cs = pio_chipselect;
    @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    evt_ready = 1'b1;
    while ((cap != '0 || ph != 0 || q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) expire("settle");
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus
  logic [N-1:0]  cs;
  logic [TW-1:0] t1, t2;
  bit            got1, got2, bad;
  int            n;

  initial begin
    #1 reset = 1'b1;
    en = 1;
    repeat (2) @(negedge clk);
    chk("rst_cs", pio_chipselect, 4'b0000);
    chk("rst_wr_n", pio_write_n, 1'b1);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_irq", irq_out, 1'b0);
    chk("rst_data", evt_data, 20'h0);
    chk("rst_ovf", overflow_cnt, 8'd0);
    #2 reset = 1'b0;

    // single source, level 1
    evt_ready = 1'b1;
    pdata[1] = 32'h5;
    raise(4'b0010);
    n = 0;
    while (pio_chipselect == '0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) expire("single_read");
    chk("single_read_cs", pio_chipselect, 4'b0010);
    chk("single_read_addr", pio_address, 2'd0);
    chk("single_read_wr_n", pio_write_n, 1'b1);
    n = 0;
    while (pio_write_n && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) expire("single_clear");
    chk("single_clr_cs", pio_chipselect, 4'b0010);
    chk("single_clr_addr", pio_address, 2'd3);
    chk("single_clr_wdata", pio_writedata, 32'd0);
    @(negedge clk);
    chk("single_valid", evt_valid, 1'b1);
    chk("single_lvl_idx", evt_data[3:0], 4'h9);
`ifndef PIO_IRQ_ARB_TIMESTAMP_EN
    chk("single_ts_zero", evt_data[EW-1:4], 16'h0);
`endif
    @(negedge clk);
    chk("single_irq_out", irq_out, 1'b1);
    settle();

    // round robin from reset
    do_reset();
    evt_ready = 1'b1;
    raise(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_clear(cs);
      chk("rr_grant", cs, 4'b0001 << i);
    end
    raise(4'b0001);
    wait_clear(cs);
    chk("rr_wrap", cs, 4'b0001);
    settle();

    // timestamp: two events raised 100 cycles apart
    edge_in = 4'b0001; got1 = 0; got2 = 0; t1 = '0; t2 = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); edge_in = '0;
      if (evt_valid && evt_data[2:0] == 3'd0 && !got1) begin t1 = evt_data[EW-1:4]; got1 = 1; end
    end
    edge_in = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); edge_in = '0;
      if (evt_valid && evt_data[2:0] == 3'd0 && !got2) begin t2 = evt_data[EW-1:4]; got2 = 1; end
    end
    if (!got1 || !got2) expire("ts_events");
`ifdef PIO_IRQ_ARB_TIMESTAMP_EN
    chk("ts_delta", TW'(t2 - t1), 16'd100);
`else
    chk("ts_first_zero", t1, 16'd0);
    chk("ts_second_zero", t2, 16'd0);
`endif
    settle();

    // FIFO full, overflow saturation, resume
    do_reset();
    evt_ready = 1'b0;
    pdata[0] = 32'h0; pdata[1] = 32'h1; pdata[2] = 32'h1;
    raise(4'b0111);
    wait_clear(cs); chk("full_g0", cs, 4'b0001);
    wait_clear(cs); chk("full_g1", cs, 4'b0010);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pio_chipselect != '0) bad = 1;
    end
    chk("full_no_cs", bad, 1'b0);
    chk("full_ovf_sat", overflow_cnt, 8'd255);
    chk("full_head", evt_data[3:0], 4'h0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    wait_clear(cs); chk("resume_g2", cs, 4'b0100);
    @(negedge clk);
    chk("order_head", evt_data[3:0], 4'h9);
    settle();

    // reset while in CAPT with a queued event
    do_reset();
    evt_ready = 1'b0;
    raise(4'b1000);
    wait_clear(cs);
    raise(4'b0100);
    n = 0;
    while (ph != 2 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) expire("capt_wait");
    #1 reset = 1'b1;
    #1;
    chk("capt_rst_cs", pio_chipselect, 4'b0000);
    chk("capt_rst_wr_n", pio_write_n, 1'b1);
    chk("capt_rst_valid", evt_valid, 1'b0);
    chk("capt_rst_irq", irq_out, 1'b0);
    chk("capt_rst_data", evt_data, 20'h0);
    @(negedge clk); #2 reset = 1'b0;
    evt_ready = 1'b1;
    wait_clear(cs); chk("capt_reservice", cs, 4'b0100);
    settle();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      edge_in = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      evt_ready = (i < 1200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
      for (int k = 0; k < N; k++) pdata[k] = $urandom;
      if (i == 1700) begin
        #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
      end
    end
    edge_in = '0;
    settle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
